// File: rtl/weight_loader_1.sv
// Assembles KERN_SIZE coefficients from a FWFT FIFO into a kernel bank and presents it under valid/ready.
// Latency: kern_valid rises the cycle after the completing pop; optional WEIGHT_LOADER_DBUF_EN adds an output bank.
// Backpressure: while the presented kernel is unaccepted, the bank is frozen and popping stops once no bank is free.
module weight_loader_1 #(
  parameter int COEFF_WIDTH = 16,
  parameter int KERN_SIZE   = 9,
  parameter int NUM_KERNELS = 16
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst,
  input  logic [COEFF_WIDTH-1:0]            input_V_dout,
  input  logic                              input_V_empty_n,
  output logic                              input_V_read,
  output logic [KERN_SIZE*COEFF_WIDTH-1:0]  kern_flat,
  output logic                              kern_valid,
  input  logic                              kern_ready,
  output logic                              kern_last
);

  localparam int CIW = $clog2(KERN_SIZE);
  localparam int KIW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int BW  = KERN_SIZE * COEFF_WIDTH;
  localparam logic [CIW-1:0] C_LAST = CIW'(KERN_SIZE - 1);
  localparam logic [KIW-1:0] K_LAST = KIW'(NUM_KERNELS - 1);

  logic [CIW-1:0] cidx;
  logic [KIW-1:0] kidx;
  logic [BW-1:0]  fill_bank;
  logic           accept;
  logic           pop;
  logic           complete;
  logic           hs;

  // Reset gates the pop so nothing is consumed while state is held cleared.
  assign pop          = accept & input_V_empty_n & ~ap_rst;
  assign input_V_read = pop;
  assign complete     = pop & (cidx == C_LAST);
  assign hs           = kern_valid & kern_ready;
  assign kern_last    = kern_valid & (kidx == K_LAST);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cidx      <= '0;
      fill_bank <= '0;
    end else if (pop) begin
      fill_bank[int'(cidx)*COEFF_WIDTH +: COEFF_WIDTH] <= input_V_dout;
      cidx <= (cidx == C_LAST) ? '0 : cidx + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      kidx <= '0;
    end else if (hs) begin
      kidx <= (kidx == K_LAST) ? '0 : kidx + 1'b1;
    end
  end

`ifdef WEIGHT_LOADER_DBUF_EN
  logic [BW-1:0] out_bank;
  logic [BW-1:0] fill_merged;
  logic          fill_full;
  logic          out_free;

  assign accept    = ~fill_full;
  assign out_free  = ~kern_valid | kern_ready;
  assign kern_flat = out_bank;

  // The final coefficient is still on the FIFO head at the completing edge.
  always_comb begin
    fill_merged = fill_bank;
    fill_merged[BW-1 -: COEFF_WIDTH] = input_V_dout;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_bank   <= '0;
      kern_valid <= 1'b0;
      fill_full  <= 1'b0;
    end else if (complete) begin
      if (out_free) begin
        out_bank   <= fill_merged;
        kern_valid <= 1'b1;
      end else begin
        fill_full <= 1'b1;
      end
    end else if (hs) begin
      if (fill_full) begin
        out_bank  <= fill_bank;
        fill_full <= 1'b0;
      end else begin
        kern_valid <= 1'b0;
      end
    end
  end
`else
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0] state;

  assign accept     = (state == S_FILL);
  assign kern_valid = (state == S_HOLD);
  assign kern_flat  = fill_bank;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= S_FILL;
    end else begin
      case (state)
        S_FILL:  if (complete)   state <= S_HOLD;
        default: if (kern_ready) state <= S_FILL;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_weight_loader_1.sv
// Directed bench for weight_loader_1: fill, underflow, backpressure, kernel count wrap, mid-kernel reset, streaming.
module tb_weight_loader_1;

  localparam int CW = 16;
  localparam int KS = 9;
  localparam int NK = 16;
  localparam int BW = CW * KS;
`ifdef WEIGHT_LOADER_DBUF_EN
  localparam int BP_POPS   = KS;
  localparam int PERIOD_K  = KS;
  localparam int B2B_GAPS  = 0;
`else
  localparam int BP_POPS   = 0;
  localparam int PERIOD_K  = KS + 1;
  localparam int B2B_GAPS  = 14;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] dout = '0;
  logic          empty_n = 1'b0;
  logic          input_V_read;
  logic [BW-1:0] kern_flat;
  logic          kern_valid;
  logic          kern_ready;
  logic          kern_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int last_pop_cyc = 0;
  int kidx_exp = 0;
  logic [CW-1:0] q[$];

  weight_loader_1 #(.COEFF_WIDTH(CW), .KERN_SIZE(KS), .NUM_KERNELS(NK)) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .input_V_dout(dout),
    .input_V_empty_n(empty_n),
    .input_V_read(input_V_read),
    .kern_flat(kern_flat),
    .kern_valid(kern_valid),
    .kern_ready(kern_ready),
    .kern_last(kern_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FWFT FIFO model: head presented at negedge, pop recorded for the following rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      dout    = q[0];
      empty_n = 1'b1;
    end else begin
      empty_n = 1'b0;
    end
    #1;
    if (input_V_read === 1'b1 && empty_n && q.size() > 0) begin
      void'(q.pop_front());
      pop_cnt++;
      last_pop_cyc = cyc + 1;
    end
  end

  function automatic logic [BW-1:0] mk(input int base);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < KS; i++) r[i*CW +: CW] = CW'(base + i);
    return r;
  endfunction

  task automatic push_k(input int base);
    for (int i = 0; i < KS; i++) q.push_back(CW'(base + i));
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #2;
      if (kern_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    kern_ready = 1'b0;
    push_k(1);
    repeat (3) @(posedge clk);
    #2;
    checks++; if (kern_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", kern_valid); end
    checks++; if (kern_flat !== '0) begin errors++; $display("FAIL reset_flat got %h want 0", kern_flat); end
    checks++; if (kern_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", kern_last); end
    checks++; if (input_V_read !== 1'b0) begin errors++; $display("FAIL reset_read got %0b want 0", input_V_read); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    bit ok;
    kern_ready = 1'b1;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL fill_timeout got no kern_valid want 1"); end
    checks++; if (cyc !== last_pop_cyc) begin errors++; $display("FAIL fill_latency got cycle %0d want %0d", cyc, last_pop_cyc); end
    checks++; if (input_V_read !== 1'b0) begin errors++; $display("FAIL fill_read_hold got %0b want 0", input_V_read); end
    checks++; if (kern_flat !== mk(1)) begin errors++; $display("FAIL fill_flat got %h want %h", kern_flat, mk(1)); end
    checks++; if (kern_last !== 1'b0) begin errors++; $display("FAIL fill_last got %0b want 0", kern_last); end
    checks++; if (pop_cnt !== KS) begin errors++; $display("FAIL fill_pops got %0d want %0d", pop_cnt, KS); end
    kidx_exp = 1;
    @(posedge clk); #2;
    checks++; if (kern_valid !== 1'b0) begin errors++; $display("FAIL fill_handshake got valid %0b want 0", kern_valid); end
  endtask

  task automatic test_underflow();
    bit ok;
    int p0;
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) q.push_back(CW'(1 + i));
    for (int n = 0; n < 20 && pop_cnt < p0 + 4; n++) begin
      @(posedge clk); #2;
    end
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #2;
      checks++;
      if (input_V_read !== 1'b0 || pop_cnt !== p0 + 4 || kern_valid !== 1'b0) begin
        errors++;
        $display("FAIL underflow_gap got read %0b pops %0d valid %0b want 0 %0d 0", input_V_read, pop_cnt - p0, kern_valid, 4);
      end
    end
    for (int i = 4; i < KS; i++) q.push_back(CW'(1 + i));
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL underflow_timeout got no kern_valid want 1"); end
    checks++; if (kern_flat !== mk(1)) begin errors++; $display("FAIL underflow_flat got %h want %h", kern_flat, mk(1)); end
    checks++; if (pop_cnt !== p0 + KS) begin errors++; $display("FAIL underflow_pops got %0d want %0d", pop_cnt - p0, KS); end
    kidx_exp = 2;
  endtask

  task automatic test_backpressure();
    bit ok;
    int p0;
    @(posedge clk); #2;
    kern_ready = 1'b0;
    push_k(16'h10);
    push_k(16'h20);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got no kern_valid want 1"); end
    checks++; if (kern_flat !== mk(16'h10)) begin errors++; $display("FAIL bp_flat got %h want %h", kern_flat, mk(16'h10)); end
    p0 = pop_cnt;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #2;
      checks++;
      if (kern_valid !== 1'b1 || kern_flat !== mk(16'h10) || kern_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid %0b last %0b flat %h want 1 0 %h", n, kern_valid, kern_last, kern_flat, mk(16'h10));
      end
    end
    checks++; if (pop_cnt - p0 !== BP_POPS) begin errors++; $display("FAIL bp_pops got %0d want %0d", pop_cnt - p0, BP_POPS); end
    checks++; if (input_V_read !== 1'b0) begin errors++; $display("FAIL bp_read_stall got %0b want 0", input_V_read); end
    kern_ready = 1'b1;
    wait_valid(ok);
    kidx_exp = 3;
    checks++; if (!ok) begin errors++; $display("FAIL bp_second_timeout got no kern_valid want 1"); end
    checks++; if (kern_flat !== mk(16'h20)) begin errors++; $display("FAIL bp_second_flat got %h want %h", kern_flat, mk(16'h20)); end
    checks++; if (kern_last !== 1'b0) begin errors++; $display("FAIL bp_second_last got %0b want 0", kern_last); end
    kidx_exp = 4;
  endtask

  task automatic test_kern_last();
    bit ok;
    for (int k = 0; k < 13; k++) push_k(16'h100 + k * 16);
    for (int k = 0; k < 13; k++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL last_timeout kernel %0d got no kern_valid want 1", k); end
      checks++; if (kern_flat !== mk(16'h100 + k * 16)) begin errors++; $display("FAIL last_flat kernel %0d got %h want %h", k, kern_flat, mk(16'h100 + k * 16)); end
      checks++; if (kern_last !== (kidx_exp == NK - 1)) begin errors++; $display("FAIL last_flag index %0d got %0b want %0b", kidx_exp, kern_last, kidx_exp == NK - 1); end
      kidx_exp = (kidx_exp + 1) % NK;
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int p0;
    push_k(16'h200);
    wait_valid(ok);
    checks++; if (kern_flat !== mk(16'h200) || !ok) begin errors++; $display("FAIL rst_pre_flat got %h want %h", kern_flat, mk(16'h200)); end
    kidx_exp = (kidx_exp + 1) % NK;
    p0 = pop_cnt;
    for (int i = 0; i < 5; i++) q.push_back(CW'(16'h300 + i));
    for (int n = 0; n < 30 && pop_cnt < p0 + 5; n++) begin
      @(posedge clk); #2;
    end
    checks++; if (kern_valid !== 1'b0 || pop_cnt !== p0 + 5) begin errors++; $display("FAIL rst_partial got valid %0b pops %0d want 0 5", kern_valid, pop_cnt - p0); end
    rst = 1'b1;
    #1;
    checks++; if (kern_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", kern_valid); end
    checks++; if (kern_flat !== '0) begin errors++; $display("FAIL rst_mid_flat got %h want 0", kern_flat); end
    checks++; if (kern_last !== 1'b0) begin errors++; $display("FAIL rst_mid_last got %0b want 0", kern_last); end
    checks++; if (input_V_read !== 1'b0) begin errors++; $display("FAIL rst_mid_read got %0b want 0", input_V_read); end
    kidx_exp = 0;
    push_k(16'h400);
    repeat (2) @(posedge clk);
    #2;
    checks++; if (input_V_read !== 1'b0) begin errors++; $display("FAIL rst_hold_read got %0b want 0", input_V_read); end
    rst = 1'b0;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_post_timeout got no kern_valid want 1"); end
    checks++; if (kern_flat !== mk(16'h400)) begin errors++; $display("FAIL rst_post_flat got %h want %h", kern_flat, mk(16'h400)); end
    checks++; if (kern_last !== 1'b0) begin errors++; $display("FAIL rst_post_last got %0b want 0", kern_last); end
    kidx_exp = 1;
  endtask

  task automatic test_back_to_back();
    int p0, seen, prev, gaps;
    p0 = pop_cnt;
    seen = 0;
    prev = 0;
    gaps = 0;
    for (int k = 0; k < 15; k++) push_k(16'h500 + k * 16);
    for (int n = 0; n < 15 * 12 && seen < 15; n++) begin
      @(posedge clk); #2;
      if (pop_cnt > p0 && q.size() > 0 && input_V_read !== 1'b1) gaps++;
      if (kern_valid === 1'b1) begin
        if (seen > 0) begin
          checks++; if (cyc - prev !== PERIOD_K) begin errors++; $display("FAIL b2b_period kernel %0d got %0d want %0d", seen, cyc - prev, PERIOD_K); end
        end
        checks++; if (kern_flat !== mk(16'h500 + seen * 16)) begin errors++; $display("FAIL b2b_flat kernel %0d got %h want %h", seen, kern_flat, mk(16'h500 + seen * 16)); end
        checks++; if (kern_last !== (kidx_exp == NK - 1)) begin errors++; $display("FAIL b2b_last index %0d got %0b want %0b", kidx_exp, kern_last, kidx_exp == NK - 1); end
        kidx_exp = (kidx_exp + 1) % NK;
        prev = cyc;
        seen++;
      end
    end
    checks++; if (seen !== 15) begin errors++; $display("FAIL b2b_count got %0d want 15", seen); end
    checks++; if (gaps !== B2B_GAPS) begin errors++; $display("FAIL b2b_read_gaps got %0d want %0d", gaps, B2B_GAPS); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_underflow();
    test_backpressure();
    test_kern_last();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
